bram_rr_arbiter: RTL
====================

// Module: bram_rr_arbiter
// PURPOSE
//  Shares one single-port BRAM (1-cycle registered read, read-first on write) among NUM_REQ
//  requesters. Round-robin grant, valid/ready request handshake, optional lock for bursts.
//  Pipelines each command into the BRAM and routes read data back to the issuing requester.
//  Sits between the seed-table/tile engines and their shared scratch BRAM instance.
// PARAMETERS
//  NUM_REQ     4  number of requesters (2..16)
//  ADDR_WIDTH  4  BRAM address width; must equal the attached BRAM's ADDR_WIDTH
//  DATA_WIDTH  8  BRAM data width; must equal the attached BRAM's DATA_WIDTH
// PORTS
//  clk            in   1                   clock
//  rst            in   1                   synchronous, active-high reset
//  req_valid      in   NUM_REQ             per-requester command valid
//  req_ready      out  NUM_REQ             one-hot grant; handshake = valid & ready
//  req_lock       in   NUM_REQ             holds the grant on the current owner while asserted
//  req_wr_en      in   NUM_REQ             1 = write, 0 = read
//  req_addr       in   NUM_REQ*ADDR_WIDTH  flat; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  req_wdata      in   NUM_REQ*DATA_WIDTH  flat; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  rsp_valid      out  NUM_REQ             one-hot read-response strobe
//  rsp_data       out  DATA_WIDTH          read data; qualified by rsp_valid
//  bram_addr      out  ADDR_WIDTH          to BRAM addr (registered)
//  bram_write_en  out  1                   to BRAM write_en (registered)
//  bram_data_in   out  DATA_WIDTH          to BRAM data_in (registered)
//  bram_data_out  in   DATA_WIDTH          from BRAM data_out
// BEHAVIOUR
//  Reset: req_ready=0, rsp_valid=0, bram_write_en=0, bram_addr=0, bram_data_in=0,
//   rr_ptr=0, owner=none, in-flight reads discarded (no rsp_valid after rst).
//  Grant is combinational from req_valid, rr_ptr, owner/lock. At most one req_ready bit is set.
//   req_ready[i]=1 only if req_valid[i]=1.
//  Round-robin: search from rr_ptr upward, wrap at NUM_REQ-1 -> 0. On handshake by i,
//   rr_ptr <= (i+1) mod NUM_REQ.
//  Lock: if owner k handshakes with req_lock[k]=1, owner <= k. While owner==k and
//   req_lock[k]=1, only k may be granted. This holds even in cycles where req_valid[k]=0
//   (bubble, no grant). Owner is cleared when k handshakes with req_lock[k]=0, or when
//   req_lock[k] drops while k is idle.
//  Issue stage (edge E0 = handshake edge): bram_addr/bram_data_in <= granted fields;
//   bram_write_en <= req_wr_en. With no handshake: bram_write_en <= 0 and addr/data hold.
//  BRAM samples at E1. Reads: rd_tag pipeline sets rsp_valid[i] for the cycle after E1.
//   rsp_data = bram_data_out (pass-through). Read latency = 2 edges from accept.
//  Writes produce no response. A read issued on the cycle after a write to the same address
//   returns the new data. Throughput: 1 command/cycle, no response back-pressure.
//   Requesters must always accept responses.
//  NUM_REQ=1 degenerates to a registered pass-through with req_ready=req_valid.
// STRUCTURE
//  Shared header bram_arb_defs.vh: `define for CLOG2 macro/function, NUM_REQ max,
//   flat-bus slice macros.
//  Sub-module rr_priority_select (combinational: valid vector + ptr -> one-hot grant + index).
//  Top: rr_ptr, owner regs, issue regs, 1-deep rd_tag shift (one-hot NUM_REQ + valid).
// TESTING (bench instantiates BRAM with ADDR_WIDTH=4, DATA_WIDTH=8, NUM_REQ=4)
//  1 rst held 3 cycles with all req_valid=1 -> req_ready=0, bram_write_en=0, rsp_valid=0
//   throughout; after release rr_ptr=0 so req0 granted first.
//  2 req0 writes addr 3 = 0xA5; next cycle req2 reads addr 3 -> rsp_valid=4'b0100,
//   rsp_data=0xA5 exactly 2 edges after req2 accept.
//  3 req_valid=4'b1111 held, reads -> grants cycle 0,1,2,3,0,... one per cycle;
//   rsp_valid follows the same sequence delayed 2 cycles.
//  4 req1 lock=1, 4 reads while req3 valid -> req3 starved until req1 handshakes with lock=0;
//   req3 granted next cycle.
//  5 rst asserted the cycle after a read accept -> no rsp_valid; bram_write_en=0.
//   First post-reset grant goes to lowest valid index.
//  6 random mix, 10k cycles vs reference model -> every read returns the last written value;
//   never two ready bits; no lost/duplicated responses.

Source files
------------

// File: rtl/bram_rr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// bram_rr_arbiter_pkg
//   Shared helpers for the BRAM round-robin arbiter and its priority selector.
//   idx_width(n) : width of an index able to address n requesters. It is at
//                  least 1 so that a single-requester build still has a legal
//                  vector width.
// ----------------------------------------------------------------------------
package bram_rr_arbiter_pkg;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bram_rr_arbiter_rr_priority_select.sv
// ----------------------------------------------------------------------------
// bram_rr_arbiter_rr_priority_select
//   Combinational round-robin pick. It scans valid_i starting at ptr_i,
//   moving upward and wrapping from NUM_REQ-1 back to 0. It returns the first
//   valid requester.
// Ports
//   valid_i  in  NUM_REQ  candidate requesters
//   ptr_i    in  IDX_W    requester with highest priority this cycle
//   grant_o  out NUM_REQ  one-hot pick, zero when valid_i is zero
//   idx_o    out IDX_W    index of the pick, don't-care when grant_o is zero
// ----------------------------------------------------------------------------
module bram_rr_arbiter_rr_priority_select
    import bram_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o
);

    // One spare bit so that ptr + offset cannot overflow before the wrap.
    logic [IDX_W:0] pos;

    // The scan runs from the farthest offset down to offset 0. The last
    // match to be written is the one nearest the pointer, so it wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        pos     = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            pos = {1'b0, ptr_i} + (IDX_W+1)'(off);
            if (pos >= (IDX_W+1)'(NUM_REQ)) begin
                pos = pos - (IDX_W+1)'(NUM_REQ);
            end
            if (valid_i[pos[IDX_W-1:0]]) begin
                grant_o                 = '0;
                grant_o[pos[IDX_W-1:0]] = 1'b1;
                idx_o                   = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/bram_rr_arbiter.sv
// ----------------------------------------------------------------------------
// bram_rr_arbiter
//   Shares one single-port BRAM among NUM_REQ requesters. The BRAM has a
//   1-cycle registered read and returns the old data on a write.
//   - The grant is round-robin. A requester that holds req_lock keeps the
//     grant to itself.
//   - Each accepted command is registered onto the BRAM port.
//   - A two-stage read tag sends the BRAM read data back to the requester
//     that issued the read.
// Ports
//   clk, rst        clock; synchronous active-high reset
//   req_valid/ready command handshake, one-hot ready
//   req_lock        hold the grant on the current owner
//   req_wr_en       1 = write, 0 = read
//   req_addr/wdata  flat per-requester command fields
//   rsp_valid       one-hot read-response strobe
//   rsp_data        read data (bram_data_out passed straight through)
//   bram_*          registered BRAM command port, plus bram_data_out back in
// ----------------------------------------------------------------------------
module bram_rr_arbiter
    import bram_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ-1:0]            req_wr_en,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ADDR_WIDTH-1:0]         bram_addr,
    output logic                          bram_write_en,
    output logic [DATA_WIDTH-1:0]         bram_data_in,
    input  logic [DATA_WIDTH-1:0]         bram_data_out
);

    localparam int IDX_W = idx_width(NUM_REQ);

    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic                  owner_vld_q, owner_vld_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  we_q;
    logic [NUM_REQ-1:0]    rd_tag_q;      // read issued to the BRAM at the last edge
    logic [NUM_REQ-1:0]    rsp_valid_q;   // that read's data is now on bram_data_out

    logic [NUM_REQ-1:0]    rr_grant, grant;
    logic [IDX_W-1:0]      rr_idx, grant_idx;
    logic                  hs;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unflatten
            assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    bram_rr_arbiter_rr_priority_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_select (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (rr_grant),
        .idx_o   (rr_idx)
    );

    // The owner keeps priority while it is valid. This includes the final
    // burst beat, where lock is already low. When the owner is idle and still
    // holds lock, the cycle is a bubble. When the owner is idle and has
    // dropped lock, round-robin arbitration resumes in that same cycle.
    always_comb begin
        grant     = '0;
        grant_idx = rr_idx;
        if (!rst) begin
            if (owner_vld_q && req_valid[owner_q]) begin
                grant[owner_q] = 1'b1;
                grant_idx      = owner_q;
            end else if (owner_vld_q && req_lock[owner_q]) begin
                grant = '0;
            end else begin
                grant = rr_grant;
            end
        end
    end

    assign hs = |grant;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        if (hs) begin
            rr_ptr_d    = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            owner_d     = grant_idx;
            owner_vld_d = req_lock[grant_idx];
        end else if (owner_vld_q && !req_lock[owner_q]) begin
            owner_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            rd_tag_q    <= '0;
            rsp_valid_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            // When no command is accepted, addr and data hold their values
            // and only the write enable is cleared.
            if (hs) begin
                addr_q  <= addr_arr[grant_idx];
                wdata_q <= wdata_arr[grant_idx];
                we_q    <= req_wr_en[grant_idx];
            end else begin
                we_q    <= 1'b0;
            end
            rd_tag_q    <= (hs && !req_wr_en[grant_idx]) ? grant : '0;
            rsp_valid_q <= rd_tag_q;
        end
    end

    assign req_ready     = grant;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = bram_data_out;
    assign bram_addr     = addr_q;
    assign bram_write_en = we_q;
    assign bram_data_in  = wdata_q;

endmodule
